imem_boot_loader: RTL and testbench



---
 rtl/boot_pkg.sv | 17 +
 rtl/imem_boot_loader_if.sv | 21 ++
 rtl/word_packer.sv | 35 +++
 rtl/imem_boot_loader.sv | 126 ++++++++++++
 tb/tb_imem_boot_loader.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Holds the loader state encoding and the stream framing constants.
package boot_pkg;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
        CSUM,
        RUN,
        ERR
    } state_t;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream valid/ready channel feeding the boot loader.
// Ports: in_valid/in_data from master, in_ready from slave.
interface imem_boot_loader_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/word_packer.sv
// Packs big-endian bytes into 32-bit words.
// Ports: clk, rst_n, i_clr, i_en, i_byte in; o_word, o_word_valid out.
module word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid
);
    import boot_pkg::*;

    logic [23:0] r_sh;
    logic [1:0]  r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (i_clr) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (i_en) begin
            r_sh  <= {r_sh[15:0], i_byte};
            r_cnt <= r_cnt + 2'd1;
        end
    end

    // The final byte completes the word combinationally so the
    // top level can register the write on the same edge.
    assign o_word       = {r_sh, i_byte};
    assign o_word_valid = i_en && (r_cnt == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: streams header/words/checksum into instruction memory.
// Ports: clk, rst_n, bus (byte stream), load_req, cpu_pc, imem_*, status.
module imem_boot_loader #(
    parameter int DEPTH_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    imem_boot_loader_if.slave  bus,
    input  logic               load_req,
    input  logic [31:0]        cpu_pc,
    output logic [DEPTH_W-1:0] imem_raddr,
    output logic               imem_we,
    output logic [DEPTH_W-1:0] imem_waddr,
    output logic [31:0]        imem_wdata,
    output logic               cpu_rst_n,
    output logic               load_done,
    output logic               load_err
);
    import boot_pkg::*;

    localparam logic [15:0] DEPTH = 16'(2 ** DEPTH_W);

    state_t             r_state;
    state_t             w_nxt;
    logic [15:0]        r_n;
    logic [DEPTH_W:0]   r_wcnt;
    logic [7:0]         r_csum;
    logic               w_fire;
    logic               w_clr;
    logic               w_pk_en;
    logic [31:0]        w_word;
    logic               w_word_valid;
    logic [15:0]        w_n;
    logic               w_n_bad;
    logic               w_last_word;
    logic               w_unused_pc;

    assign bus.in_ready = rst_n && (r_state == HDR_HI ||
                                    r_state == HDR_LO ||
                                    r_state == DATA   ||
                                    r_state == CSUM);

    assign w_fire      = bus.in_valid && bus.in_ready;
    assign w_pk_en     = w_fire && (r_state == DATA);
    assign w_n         = {r_n[15:8], bus.in_data};
    assign w_n_bad     = (w_n == 16'd0) || (w_n > DEPTH);
    assign w_last_word = (16'(r_wcnt) == (r_n - 16'd1));
    assign w_unused_pc = ^{cpu_pc[31:DEPTH_W+2], cpu_pc[1:0]};

    word_packer u_pack (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr        (w_clr),
        .i_en         (w_pk_en),
        .i_byte       (bus.in_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_comb begin
        w_nxt = r_state;
        w_clr = 1'b0;
        unique case (r_state)
            HDR_HI: if (w_fire) w_nxt = HDR_LO;
            HDR_LO: begin
                if (w_fire) begin
                    if (w_n_bad) begin
                        w_nxt = ERR;
                    end else begin
                        w_nxt = DATA;
                        w_clr = 1'b1;
                    end
                end
            end
            DATA: if (w_word_valid && w_last_word) w_nxt = CSUM;
            CSUM: begin
                if (w_fire)
                    w_nxt = (bus.in_data == r_csum) ? RUN : ERR;
            end
            RUN:  if (load_req) w_nxt = HDR_HI;
            ERR:  if (load_req) w_nxt = HDR_HI;
            default: w_nxt = HDR_HI;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= HDR_HI;
            r_n        <= '0;
            r_wcnt     <= '0;
            r_csum     <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            cpu_rst_n  <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            r_state <= w_nxt;
            if (w_fire && r_state == HDR_HI) r_n[15:8] <= bus.in_data;
            if (w_fire && r_state == HDR_LO) r_n[7:0]  <= bus.in_data;
            if (w_clr) begin
                r_wcnt <= '0;
                r_csum <= '0;
            end else begin
                if (w_word_valid) r_wcnt <= r_wcnt + 1'b1;
                if (w_pk_en)      r_csum <= r_csum ^ bus.in_data;
            end
            imem_we <= w_word_valid;
            if (w_word_valid) begin
                imem_waddr <= r_wcnt[DEPTH_W-1:0];
                imem_wdata <= w_word;
            end
            // Status rises a cycle after entering RUN/ERR but drops
            // together with the exit, so the CPU is held in reset the
            // same cycle the loader starts accepting bytes again.
            cpu_rst_n <= (r_state == RUN) && (w_nxt == RUN);
            load_done <= (r_state == RUN) && (w_nxt == RUN);
            load_err  <= (r_state == ERR) && (w_nxt == ERR);
        end
    end

    assign imem_raddr = (r_state == RUN) ? cpu_pc[DEPTH_W+1:2]
                                         : r_wcnt[DEPTH_W-1:0];

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader against a stream-level model.
// Ports: none; drives the byte-stream interface and load_req/cpu_pc.
module tb_imem_boot_loader;

    logic        clk;
    logic        rst_n;
    logic        load_req;
    logic [31:0] cpu_pc;
    logic [7:0]  imem_raddr;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_rst_n;
    logic        load_done;
    logic        load_err;

    int n_chk;
    int n_pass;

    logic [39:0] obs_q[$];
    logic [39:0] exp_q[$];
    logic [31:0] dut_mem [256];
    logic [31:0] ref_mem [256];

    imem_boot_loader_if bus();

    imem_boot_loader #(.DEPTH_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .load_req   (load_req),
        .cpu_pc     (cpu_pc),
        .imem_raddr (imem_raddr),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            obs_q.push_back({imem_waddr, imem_wdata});
            dut_mem[imem_waddr] <= imem_wdata;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gaps,
                             input int noise);
        int t;
        int g;
        if (gaps != 0) begin
            g = $urandom_range(0, 2);
            repeat (g) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                load_req = (noise != 0) ? 1'($urandom) : 1'b0;
                @(negedge clk);
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        load_req = (noise != 0) ? 1'($urandom) : 1'b0;
        t = 0;
        while (!bus.in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t == 20) check("rdy_to", bus.in_ready, 1'b1);
        else @(negedge clk);
    endtask

    task automatic run_load(input logic [15:0] n, input int gaps,
                            input int noise, input bit bad_cs,
                            input bit idx_data);
        logic [31:0] w;
        logic [7:0]  cs;
        int          nw;
        cs = 8'h00;
        nw = (n >= 16'd1 && n <= 16'd256) ? int'(n) : 0;
        send_byte(n[15:8], gaps, 0);
        send_byte(n[7:0], gaps, 0);
        for (int i = 0; i < nw; i++) begin
            w = idx_data ? 32'(i) : $urandom;
            exp_q.push_back({8'(i), w});
            ref_mem[i] = w;
            for (int k = 3; k >= 0; k--) begin
                cs = cs ^ w[8*k +: 8];
                send_byte(w[8*k +: 8], gaps, noise);
            end
        end
        if (nw > 0) send_byte(bad_cs ? (cs ^ 8'h5A) : cs, gaps, 0);
        bus.in_valid = 1'b0;
        load_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic cmp_writes();
        int m;
        int bad;
        check("wr_cnt", obs_q.size(), exp_q.size());
        m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            check("wr_addr", obs_q[i][39:32], exp_q[i][39:32]);
            check("wr_data", obs_q[i][31:0], exp_q[i][31:0]);
        end
        obs_q.delete();
        exp_q.delete();
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (dut_mem[i] !== ref_mem[i]) bad++;
        check("mem_img", bad, 0);
    endtask

    task automatic end_check(input bit exp_run);
        check("done", load_done, exp_run);
        check("err", load_err, !exp_run);
        check("cpu_rst", cpu_rst_n, exp_run);
        check("rdy_idle", bus.in_ready, 1'b0);
        cmp_writes();
    endtask

    task automatic pulse_req();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        check("req_rdy", bus.in_ready, 1'b1);
        check("req_crst", cpu_rst_n, 1'b0);
    endtask

    initial begin
        n_chk        = 0;
        n_pass       = 0;
        rst_n        = 1'b0;
        load_req     = 1'b0;
        cpu_pc       = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        for (int i = 0; i < 256; i++) begin
            dut_mem[i] = 32'hA5A5_0000 | 32'(i);
            ref_mem[i] = 32'hA5A5_0000 | 32'(i);
        end
        repeat (2) @(negedge clk);
        check("rst_rdy", bus.in_ready, 1'b0);
        check("rst_crst", cpu_rst_n, 1'b0);
        check("rst_done", load_done, 1'b0);
        check("rst_err", load_err, 1'b0);
        check("rst_we", imem_we, 1'b0);
        check("rst_wa", imem_waddr, 8'h00);
        check("rst_wd", imem_wdata, 32'h0);
        rst_n = 1'b1;
        #1;
        check("rdy_hdr", bus.in_ready, 1'b1);
        check("raddr0", imem_raddr, 8'h00);
        @(negedge clk);

        // single word, byte by byte with latency checks
        send_byte(8'h00, 0, 0);
        send_byte(8'h01, 0, 0);
        send_byte(8'h24, 0, 0);
        send_byte(8'h21, 0, 0);
        send_byte(8'h00, 0, 0);
        send_byte(8'h04, 0, 0);
        check("we_lat", imem_we, 1'b1);
        check("we_addr", imem_waddr, 8'h00);
        check("we_data", imem_wdata, 32'h2421_0004);
        send_byte(8'h24 ^ 8'h21 ^ 8'h00 ^ 8'h04, 0, 0);
        bus.in_valid = 1'b0;
        check("we_pulse", imem_we, 1'b0);
        check("crst_lat", cpu_rst_n, 1'b0);
        @(negedge clk);
        check("crst_on", cpu_rst_n, 1'b1);
        check("done_on", load_done, 1'b1);
        exp_q.push_back({8'h00, 32'h2421_0004});
        ref_mem[0] = 32'h2421_0004;
        cmp_writes();

        // full depth, index data, stalls and ignored load_req noise
        pulse_req();
        run_load(16'd256, 1, 1, 1'b0, 1'b1);
        end_check(1'b1);
        cpu_pc = 32'h20;
        #1;
        check("raddr_pc", imem_raddr, 8'd8);
        for (int i = 0; i < 3; i++) begin
            cpu_pc = $urandom;
            #1;
            check("raddr_rnd", imem_raddr, cpu_pc[9:2]);
        end
        @(negedge clk);

        // reload one word; rest of the image must survive
        pulse_req();
        run_load(16'd1, 1, 0, 1'b0, 1'b0);
        end_check(1'b1);

        // bad headers
        pulse_req();
        run_load(16'h0000, 1, 0, 1'b0, 1'b0);
        end_check(1'b0);
        pulse_req();
        run_load(16'h0101, 1, 0, 1'b0, 1'b0);
        end_check(1'b0);

        // bad checksum, then a good load
        pulse_req();
        run_load(16'd2, 1, 0, 1'b1, 1'b0);
        end_check(1'b0);
        check("raddr_err", imem_raddr, 8'd2);
        pulse_req();
        run_load(16'd2, 1, 1, 1'b0, 1'b0);
        end_check(1'b1);

        // reset in the middle of a load
        pulse_req();
        begin
            logic [31:0] w0;
            logic [31:0] w1;
            w0 = $urandom;
            w1 = $urandom;
            send_byte(8'h00, 1, 0);
            send_byte(8'h03, 1, 0);
            for (int k = 3; k >= 0; k--) send_byte(w0[8*k +: 8], 1, 0);
            send_byte(w1[31:24], 1, 0);
            send_byte(w1[23:16], 1, 0);
            exp_q.push_back({8'h00, w0});
            ref_mem[0] = w0;
        end
        rst_n = 1'b0;
        #1;
        check("ab_rdy", bus.in_ready, 1'b0);
        check("ab_we", imem_we, 1'b0);
        check("ab_wa", imem_waddr, 8'h00);
        check("ab_wd", imem_wdata, 32'h0);
        check("ab_crst", cpu_rst_n, 1'b0);
        check("ab_done", load_done, 1'b0);
        check("ab_err", load_err, 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cmp_writes();
        @(negedge clk);
        run_load(16'd3, 1, 0, 1'b0, 1'b0);
        end_check(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
